// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared helpers for the serial pattern detector:
//   clog2        - ceiling log2, used to size registers
//   state_width  - width of the "bits matched so far" state for a pattern
//   kmp_next     - next-state entry (pattern, width, overlap, s, b), evaluated
//                  only with constant arguments so the whole transition table
//                  folds away at elaboration
//   step_e       - classification of what the FSM does at a sampling edge
package seq_detect_pkg;

  localparam int MAX_PAT_W = 16;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_ADVANCE,
    STEP_FALLBACK,
    STEP_COMPLETE
  } step_e;

  // Ceiling log2 with clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // State counts 0..pat_w-1, sized from pat_w+1 so pat_w=1 still gets one bit.
  function automatic int state_width(input int pat_w);
    return clog2(pat_w + 1);
  endfunction

  // Bit i of a pattern word, done with a shift so the index can be an int.
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] p, input int i);
    logic [MAX_PAT_W-1:0] t;
    t = p >> i;
    return t[0];
  endfunction

  // Pattern position p (0 = first bit received) lives at bit pat_w-1-p.
  // On a matching bit the state advances; on completion it drops to the
  // longest proper border (overlap) or to 0. On a mismatch it drops to the
  // longest prefix that is a suffix of the received text (matched prefix + b).
  function automatic int kmp_next(input logic [MAX_PAT_W-1:0] pattern,
                                  input int pat_w, input bit overlap,
                                  input int s, input logic b);
    int result;
    bit found;
    bit ok;
    logic seq_bit;
    result = 0;
    found = 1'b0;
    if (b == pat_bit(pattern, pat_w - 1 - s)) begin
      if (s + 1 < pat_w) begin
        result = s + 1;
      end else if (overlap) begin
        for (int k = pat_w - 1; k >= 1; k--) begin
          if (!found) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
              if (pat_bit(pattern, k - 1 - j) != pat_bit(pattern, pat_w - 1 - j)) begin
                ok = 1'b0;
              end
            end
            if (ok) begin
              result = k;
              found = 1'b1;
            end
          end
        end
      end
    end else begin
      for (int k = s; k >= 1; k--) begin
        if (!found) begin
          ok = 1'b1;
          for (int j = 0; j < k; j++) begin
            seq_bit = (s + 1 - k + j == s) ? b
                    : pat_bit(pattern, pat_w - 1 - (s + 1 - k + j));
            if (seq_bit != pat_bit(pattern, pat_w - 1 - j)) begin
              ok = 1'b0;
            end
          end
          if (ok) begin
            result = k;
            found = 1'b1;
          end
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_detect_fsm_sat_counter.sv
// sat_counter
// Saturating up-counter for detector hits; sticks at all-ones, never wraps.
// Ports:
//   CLK   - rising-edge clock
//   RST   - synchronous active-high reset, clears the count
//   inc   - add one at this edge (ignored once saturated)
//   count - current count, CNT_W bits
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, hold once every bit is set; reset wins over inc.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm
// Serial detector for a PAT_W-bit pattern on y, first bit = PATTERN[PAT_W-1].
// The transition table is built at elaboration from kmp_next, so the runtime
// logic is just a per-state mux plus the state and match registers.
// Optional hit counter is built only when SEQ_DETECT_CNT_EN is defined;
// otherwise hit_count is tied to 0 and the port list stays the same.
// Ports:
//   CLK       - rising-edge clock
//   RST       - synchronous active-high reset (overrides en)
//   en        - sample y at this edge when 1, hold everything when 0
//   y         - serial data bit
//   match     - one-cycle pulse, pattern completed at the last sampling edge
//   state     - number of pattern bits currently matched (0..PAT_W-1)
//   hit_count - saturating number of matches (0 when counter not built)
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8,
  localparam int              SW      = state_width(PAT_W)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             y,
  output logic             match,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] hit_count
);

  logic [SW-1:0]    next_on0 [PAT_W];
  logic [SW-1:0]    next_on1 [PAT_W];
  logic [PAT_W-1:0] exp_bit;
  logic [SW-1:0]    state_next;
  logic             match_next;
  step_e            step;

  // One table entry per state for each value of y, plus the bit expected in
  // that state; all are elaboration-time constants.
  for (genvar i = 0; i < PAT_W; i++) begin : g_table
    localparam int N0 = kmp_next(16'(PATTERN), PAT_W, OVERLAP != 0, i, 1'b0);
    localparam int N1 = kmp_next(16'(PATTERN), PAT_W, OVERLAP != 0, i, 1'b1);
    assign next_on0[i] = SW'(N0);
    assign next_on1[i] = SW'(N1);
    assign exp_bit[i]  = PATTERN[PAT_W-1-i];
  end

  // Look up the current state's row: a matching bit in the last state is a
  // completion, any other matching bit advances, a mismatch falls back.
  // The table already holds the post-completion state for both modes.
  always_comb begin
    state_next = state;
    step       = STEP_HOLD;
    if (en) begin
      for (int i = 0; i < PAT_W; i++) begin
        if (state == SW'(i)) begin
          if (y == exp_bit[i]) begin
            step = (i == PAT_W - 1) ? STEP_COMPLETE : STEP_ADVANCE;
          end else begin
            step = STEP_FALLBACK;
          end
          state_next = y ? next_on1[i] : next_on0[i];
        end
      end
    end
    match_next = (step == STEP_COMPLETE);
  end

  // State and match registers; a reset discards any partial match.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= '0;
      match <= 1'b0;
    end else begin
      state <= state_next;
      match <= match_next;
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hits (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (match_next),
    .count(hit_count)
  );
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm
// Drives three detectors from one stimulus stream: defaults (dut_a),
// non-overlapping (dut_b) and a 2-bit counter (dut_c). Expected values come
// from a directed table, a few hand-written sequences, and a reference model
// that searches the received-bit history directly for pattern prefixes.
module tb_seq_detect_fsm;

  localparam logic [3:0] PAT = 4'b1011;
`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic rst;
    logic en;
    logic y;
    logic m;
    int   s;
    int   c;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       y;
  logic       match_a, match_b, match_c;
  logic [2:0] state_a, state_b, state_c;
  logic [7:0] count_a, count_b;
  logic [1:0] count_c;

  int tests_run;
  int tests_failed;

  logic [31:0] hist_ov, hist_nov;
  int          len_ov, len_nov;
  logic        mdl_m_ov, mdl_m_nov;
  int          mdl_s_ov, mdl_s_nov;
  int          cnt_a, cnt_b, cnt_c;

  vec_t vecs[$];

  seq_detect_fsm dut_a (
    .CLK(clk), .RST(rst), .en(en), .y(y),
    .match(match_a), .state(state_a), .hit_count(count_a)
  );

  seq_detect_fsm #(.OVERLAP(0)) dut_b (
    .CLK(clk), .RST(rst), .en(en), .y(y),
    .match(match_b), .state(state_b), .hit_count(count_b)
  );

  seq_detect_fsm #(.CNT_W(2)) dut_c (
    .CLK(clk), .RST(rst), .en(en), .y(y),
    .match(match_c), .state(state_c), .hit_count(count_c)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit i of a word, via shift so int indices stay lint-friendly.
  function automatic logic bitOf(input logic [31:0] w, input int i);
    logic [31:0] t;
    t = w >> i;
    return t[0];
  endfunction

  // True when the newest k received bits equal the first k pattern bits.
  function automatic bit endsWithPrefix(input logic [31:0] h, input int len, input int k);
    bit ok;
    ok = (k <= len);
    for (int j = 0; j < k; j++) begin
      if (ok && (bitOf(h, k - 1 - j) != bitOf(32'(PAT), 3 - j))) ok = 1'b0;
    end
    return ok;
  endfunction

  // Longest pattern prefix (shorter than the whole pattern) ending the history.
  function automatic int longestPrefix(input logic [31:0] h, input int len);
    int best;
    best = 0;
    for (int k = 1; k < 4; k++) begin
      if (endsWithPrefix(h, len, k)) best = k;
    end
    return best;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one edge's inputs, wait past the edge, then advance the model.
  task automatic applyStimulus(input logic r, input logic e, input logic b);
    rst = r;
    en  = e;
    y   = b;
    @(posedge clk);
    #1;
    if (r) begin
      len_ov = 0;  len_nov = 0;
      hist_ov = '0; hist_nov = '0;
      mdl_m_ov = 1'b0; mdl_m_nov = 1'b0;
      mdl_s_ov = 0; mdl_s_nov = 0;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
    end else if (e) begin
      hist_ov  = {hist_ov[30:0], b};
      len_ov   = (len_ov < 32) ? len_ov + 1 : 32;
      mdl_m_ov = endsWithPrefix(hist_ov, len_ov, 4);
      mdl_s_ov = longestPrefix(hist_ov, len_ov);
      hist_nov  = {hist_nov[30:0], b};
      len_nov   = (len_nov < 32) ? len_nov + 1 : 32;
      mdl_m_nov = endsWithPrefix(hist_nov, len_nov, 4);
      if (mdl_m_nov) len_nov = 0;
      mdl_s_nov = longestPrefix(hist_nov, len_nov);
      if (mdl_m_ov) begin
        cnt_a = (cnt_a < 255) ? cnt_a + 1 : 255;
        cnt_c = (cnt_c < 3) ? cnt_c + 1 : 3;
      end
      if (mdl_m_nov) cnt_b = (cnt_b < 255) ? cnt_b + 1 : 255;
    end else begin
      mdl_m_ov = 1'b0;
      mdl_m_nov = 1'b0;
    end
  endtask

  task automatic checkModel();
    checkOutput("model match_a", int'(match_a), int'(mdl_m_ov));
    checkOutput("model state_a", int'(state_a), mdl_s_ov);
    checkOutput("model count_a", int'(count_a), CNT_ON ? cnt_a : 0);
    checkOutput("model match_b", int'(match_b), int'(mdl_m_nov));
    checkOutput("model state_b", int'(state_b), mdl_s_nov);
    checkOutput("model count_b", int'(count_b), CNT_ON ? cnt_b : 0);
    checkOutput("model match_c", int'(match_c), int'(mdl_m_ov));
    checkOutput("model state_c", int'(state_c), mdl_s_ov);
    checkOutput("model count_c", int'(count_c), CNT_ON ? cnt_c : 0);
  endtask

  task automatic addVec(input logic r, input logic e, input logic b,
                        input logic m, input int s, input int c);
    vec_t v;
    v.rst = r; v.en = e; v.y = b; v.m = m; v.s = s; v.c = c;
    vecs.push_back(v);
  endtask

  // Directed table for dut_a, then hand-written corner sequences, then random.
  initial begin
    int n_match;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; en = 1'b0; y = 1'b0;
    len_ov = 0; len_nov = 0; hist_ov = '0; hist_nov = '0;
    mdl_m_ov = 1'b0; mdl_m_nov = 1'b0; mdl_s_ov = 0; mdl_s_nov = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;

    addVec(1, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 1, 0); addVec(0, 1, 0, 0, 2, 0); addVec(0, 1, 1, 0, 3, 0);
    addVec(0, 1, 1, 1, 1, 1); addVec(0, 1, 0, 0, 2, 1); addVec(0, 1, 1, 0, 3, 1);
    addVec(0, 1, 1, 1, 1, 2);
    addVec(1, 1, 1, 0, 0, 0);
    addVec(0, 1, 1, 0, 1, 0); addVec(0, 1, 1, 0, 1, 0); addVec(0, 1, 0, 0, 2, 0);
    addVec(0, 1, 1, 0, 3, 0); addVec(0, 1, 1, 1, 1, 1);
    addVec(1, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 1, 0); addVec(0, 1, 0, 0, 2, 0);
    addVec(0, 0, 1, 0, 2, 0); addVec(0, 0, 0, 0, 2, 0); addVec(0, 0, 1, 0, 2, 0);
    addVec(0, 1, 1, 0, 3, 0); addVec(0, 1, 1, 1, 1, 1);
    addVec(1, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 1, 0); addVec(0, 1, 0, 0, 2, 0); addVec(0, 1, 1, 0, 3, 0);
    addVec(1, 1, 1, 0, 0, 0); addVec(0, 1, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].y);
      checkOutput($sformatf("vec%0d match", i), int'(match_a), int'(vecs[i].m));
      checkOutput($sformatf("vec%0d state", i), int'(state_a), vecs[i].s);
      checkOutput($sformatf("vec%0d count", i), int'(count_a), CNT_ON ? vecs[i].c : 0);
      checkModel();
    end

    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 1); applyStimulus(0, 1, 0); applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    checkOutput("nonoverlap first match", int'(match_b), 1);
    checkOutput("nonoverlap restart state", int'(state_b), 0);
    applyStimulus(0, 1, 0); applyStimulus(0, 1, 1); applyStimulus(0, 1, 1);
    checkOutput("nonoverlap no second match", int'(match_b), 0);
    checkOutput("nonoverlap final state", int'(state_b), 1);
    checkOutput("nonoverlap count", int'(count_b), CNT_ON ? 1 : 0);
    checkOutput("overlap second match", int'(match_a), 1);

    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 1); applyStimulus(0, 1, 0); applyStimulus(0, 1, 1);
    n_match = 0;
    for (int r = 0; r < 6; r++) begin
      if (r > 0) begin
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 1);
      end
      applyStimulus(0, 1, 1);
      n_match++;
      checkOutput($sformatf("sat match %0d", n_match), int'(match_c), 1);
      checkOutput($sformatf("sat count %0d", n_match), int'(count_c),
                  CNT_ON ? ((n_match < 3) ? n_match : 3) : 0);
      checkModel();
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                    1'($urandom_range(0, 1)));
      checkModel();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
